// File: rtl/vend_pkg.sv
// vend_pkg: definitions shared by the vending-machine front end and its FSM.
//   - 2-bit coin codes driven on D_out / accepted on the FSM's D_in
//   - issue FSM state type for coin_input_conditioner
//   - default debounce length
package vend_pkg;

  typedef logic [1:0] coin_code_t;

  localparam coin_code_t COIN_NONE = 2'b00;
  localparam coin_code_t COIN_HALF = 2'b01;
  localparam coin_code_t COIN_ONE  = 2'b10;
  localparam coin_code_t COIN_BOTH = 2'b11;

  // IDLE: nothing waiting. HOLD: one code parked in pend until the gate opens.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } issue_state_t;

  localparam int unsigned DEB_CYCLES_DEF = 16;
  localparam int unsigned CNT_W_DEF      = 5;

  // Same-cycle events combine bitwise: half -> bit 0, one -> bit 1.
  function automatic coin_code_t merge_code(input logic half_ev, input logic one_ev);
    return {one_ev, half_ev};
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: conditions one raw coin switch.
//   Clk     in   system clock, rising edge
//   Reset_n in   synchronous active-low reset
//   raw     in   asynchronous, bouncy, active-high switch
//   deb     out  debounced level
//   rise    out  one-cycle pulse on the edge where deb goes 0 -> 1
// The raw input is brought in through a 2-flop synchroniser; the synced
// value must disagree with deb for DEB_CYCLES consecutive cycles before deb
// follows it.
module coin_debounce
  import vend_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic raw,
  output logic deb,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      deb    <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      rise   <= 1'b0;
      if (sync_2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb  <= sync_2;
        cnt  <= '0;
        // Event only on a press; a release settles silently.
        rise <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_input_conditioner.sv
// coin_input_conditioner: front end of the vending Moore FSM.
//   Clk            in   system clock, rising edge
//   Reset_n        in   synchronous active-low reset
//   Coin_half_raw  in   raw half-unit coin switch (async, bouncy)
//   Coin_one_raw   in   raw one-unit coin switch (async, bouncy)
//   Vend_busy      in   downstream FSM is dispensing
//   D_out          out  registered 1-cycle coin code (00/01/10/11)
//   Coin_err       out  1-cycle pulse when a coin event is dropped
// Each switch is synchronised and debounced; settled presses become a
// one-cycle code. A code is only driven when the FSM is idle and the
// previous cycle's D_out was 00; one code can be parked while blocked.
module coin_input_conditioner
  import vend_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Coin_half_raw,
  input  logic       Coin_one_raw,
  input  logic       Vend_busy,
  output logic [1:0] D_out,
  output logic       Coin_err
);

  logic         half_deb;
  logic         half_rise;
  logic         one_deb;
  logic         one_rise;
  coin_code_t   code;
  logic         gate_open;
  logic         have_event;
  issue_state_t state;
  coin_code_t   pend;

  coin_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_half_deb (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .raw     (Coin_half_raw),
    .deb     (half_deb),
    .rise    (half_rise)
  );

  coin_debounce #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_one_deb (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .raw     (Coin_one_raw),
    .deb     (one_deb),
    .rise    (one_rise)
  );

  // rise is only ever set together with deb going high, so qualifying with
  // deb leaves the event unchanged.
  always_comb begin
    code       = merge_code(half_rise & half_deb, one_rise & one_deb);
    have_event = (code != COIN_NONE);
    gate_open  = !Vend_busy && (D_out == COIN_NONE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pend     <= COIN_NONE;
      D_out    <= COIN_NONE;
      Coin_err <= 1'b0;
    end else begin
      D_out    <= COIN_NONE;
      Coin_err <= 1'b0;
      case (state)
        IDLE: begin
          if (have_event) begin
            if (gate_open) begin
              D_out <= code;
            end else begin
              pend  <= code;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (gate_open) begin
            D_out <= pend;
            if (have_event) begin
              pend <= code;
            end else begin
              pend  <= COIN_NONE;
              state <= IDLE;
            end
          end else if (have_event) begin
            Coin_err <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          pend  <= COIN_NONE;
        end
      endcase
    end
  end

endmodule
